// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM state encoding and address-mux select codes.
package vram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_VID_SETUP  = 3'd1,
    ST_VID_READ   = 3'd2,
    ST_CPU_SETUP  = 3'd3,
    ST_CPU_ACCESS = 3'd4,
    ST_CPU_DONE   = 3'd5
  } arb_state_e;

  localparam logic MUX_SEL_VID = 1'b0;
  localparam logic MUX_SEL_CPU = 1'b1;

endpackage

// File: rtl/vram_addr_mux.sv
// 2:1 VRAM address multiplexer with active-low enable; drives zero while disabled.
module vram_addr_mux
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  mux_select,
  input  logic                  mux_enable_bar,
  output logic [ADDR_WIDTH-1:0] ram_addr
);

  always_comb begin
    ram_addr = '0;
    if (!mux_enable_bar) begin
      ram_addr = (mux_select == MUX_SEL_CPU) ? cpu_addr : vid_addr;
    end
  end

endmodule

// File: rtl/vram_mux_arbiter.sv
// Time-shares one asynchronous VRAM between the CPU bus and the video fetch unit.
// Define VRAM_ARB_FAIR_EN to alternate priority after a video grant; default is strict video priority.
//
// state         | meaning
// --------------+---------------------------------------------------
// ST_IDLE       | mux disabled, strobes high, arbitrate
// ST_VID_SETUP  | video address on mux, OE low
// ST_VID_READ   | OE held low, RAM data latched into Vid_data at exit
// ST_CPU_SETUP  | CPU address on mux, no strobe (address setup)
// ST_CPU_ACCESS | WE low for write or OE low for read
// ST_CPU_DONE   | Cpu_ack high, strobes high, mux disabled
module vram_mux_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clk,
  input  logic                  Clear_bar,
  input  logic                  Vid_req,
  input  logic [ADDR_WIDTH-1:0] Vid_addr,
  output logic [DATA_WIDTH-1:0] Vid_data,
  output logic                  Vid_valid,
  output logic                  Vid_overrun,
  input  logic                  Cpu_req,
  input  logic                  Cpu_we,
  input  logic [ADDR_WIDTH-1:0] Cpu_addr,
  input  logic [DATA_WIDTH-1:0] Cpu_wdata,
  output logic [DATA_WIDTH-1:0] Cpu_rdata,
  output logic                  Cpu_ack,
  output logic                  Cpu_wait,
  output logic                  Mux_select,
  output logic                  Mux_enable_bar,
  output logic [ADDR_WIDTH-1:0] Ram_addr,
  output logic [DATA_WIDTH-1:0] Ram_wdata,
  output logic                  Ram_we_bar,
  output logic                  Ram_oe_bar,
  input  logic [DATA_WIDTH-1:0] Ram_rdata
);

  arb_state_e            state_q, state_d;
  logic                  grant_vid, grant_cpu, cpu_first;
  logic                  vid_pend_q, vid_pend_d;
  logic [ADDR_WIDTH-1:0] vid_addr_q, vid_addr_d;
  logic [ADDR_WIDTH-1:0] vid_fetch_q, vid_fetch_d;
  logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
  logic                  cpu_we_q, cpu_we_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_WIDTH-1:0] vid_data_q, vid_data_d;
  logic                  vid_valid_q, vid_valid_d;
  logic                  vid_overrun_q, vid_overrun_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic                  mux_select_q, mux_select_d;

`ifdef VRAM_ARB_FAIR_EN
  logic last_vid_q, last_vid_d;

  always_comb begin
    last_vid_d = last_vid_q;
    if (grant_vid)      last_vid_d = 1'b1;
    else if (grant_cpu) last_vid_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) last_vid_q <= 1'b0;
    else            last_vid_q <= last_vid_d;
  end
`endif

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // A Vid_req seen in IDLE is granted directly, without waiting a cycle for the pending flag.
  always_comb begin
    cpu_first = 1'b0;
`ifdef VRAM_ARB_FAIR_EN
    cpu_first = Cpu_req & last_vid_q;
`endif
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_first) begin
          grant_cpu = 1'b1;
          state_d   = ST_CPU_SETUP;
        end else if (vid_pend_q || Vid_req) begin
          grant_vid = 1'b1;
          state_d   = ST_VID_SETUP;
        end else if (Cpu_req) begin
          grant_cpu = 1'b1;
          state_d   = ST_CPU_SETUP;
        end
      end
      ST_VID_SETUP:  state_d = ST_VID_READ;
      ST_VID_READ:   state_d = ST_IDLE;
      ST_CPU_SETUP:  state_d = ST_CPU_ACCESS;
      ST_CPU_ACCESS: state_d = ST_CPU_DONE;
      ST_CPU_DONE:   state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    Mux_enable_bar = 1'b1;
    Ram_we_bar     = 1'b1;
    Ram_oe_bar     = 1'b1;
    unique case (state_q)
      ST_VID_SETUP, ST_VID_READ: begin
        Mux_enable_bar = 1'b0;
        Ram_oe_bar     = 1'b0;
      end
      ST_CPU_SETUP: Mux_enable_bar = 1'b0;
      ST_CPU_ACCESS: begin
        Mux_enable_bar = 1'b0;
        Ram_we_bar     = ~cpu_we_q;
        Ram_oe_bar     = cpu_we_q;
      end
      default: ;
    endcase
  end

  // The fetch address is frozen at grant so a later Vid_req cannot move the address under OE.
  always_comb begin
    vid_addr_d    = Vid_req ? Vid_addr : vid_addr_q;
    vid_pend_d    = grant_vid ? 1'b0 : (vid_pend_q | Vid_req);
    vid_overrun_d = vid_overrun_q | (Vid_req & vid_pend_q);
    vid_fetch_d   = grant_vid ? vid_addr_d : vid_fetch_q;
    cpu_addr_d    = grant_cpu ? Cpu_addr : cpu_addr_q;
    cpu_we_d      = grant_cpu ? Cpu_we : cpu_we_q;
    ram_wdata_d   = grant_cpu ? Cpu_wdata : ram_wdata_q;
    mux_select_d  = grant_vid ? MUX_SEL_VID : (grant_cpu ? MUX_SEL_CPU : mux_select_q);
    vid_valid_d   = (state_q == ST_VID_READ);
    vid_data_d    = (state_q == ST_VID_READ) ? Ram_rdata : vid_data_q;
    cpu_rdata_d   = (state_q == ST_CPU_ACCESS && !cpu_we_q) ? Ram_rdata : cpu_rdata_q;
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      vid_pend_q    <= 1'b0;
      vid_addr_q    <= '0;
      vid_fetch_q   <= '0;
      cpu_addr_q    <= '0;
      cpu_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      vid_data_q    <= '0;
      vid_valid_q   <= 1'b0;
      vid_overrun_q <= 1'b0;
      cpu_rdata_q   <= '0;
      mux_select_q  <= MUX_SEL_VID;
    end else begin
      vid_pend_q    <= vid_pend_d;
      vid_addr_q    <= vid_addr_d;
      vid_fetch_q   <= vid_fetch_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_we_q      <= cpu_we_d;
      ram_wdata_q   <= ram_wdata_d;
      vid_data_q    <= vid_data_d;
      vid_valid_q   <= vid_valid_d;
      vid_overrun_q <= vid_overrun_d;
      cpu_rdata_q   <= cpu_rdata_d;
      mux_select_q  <= mux_select_d;
    end
  end

  vram_addr_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_mux (
    .vid_addr       (vid_fetch_q),
    .cpu_addr       (cpu_addr_q),
    .mux_select     (mux_select_q),
    .mux_enable_bar (Mux_enable_bar),
    .ram_addr       (Ram_addr)
  );

  assign Vid_data    = vid_data_q;
  assign Vid_valid   = vid_valid_q;
  assign Vid_overrun = vid_overrun_q;
  assign Cpu_rdata   = cpu_rdata_q;
  assign Cpu_ack     = (state_q == ST_CPU_DONE);
  assign Cpu_wait    = Cpu_req & ~Cpu_ack;
  assign Mux_select  = mux_select_q;
  assign Ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_vram_mux_arbiter.sv
// Scoreboard bench for vram_mux_arbiter: directed stimulus pushes expected results, a negedge monitor checks them.
module tb_vram_mux_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

`ifdef VRAM_ARB_FAIR_EN
  localparam int LAT_V2 = 7;
  localparam int LAT_C  = 6;
`else
  localparam int LAT_V2 = 3;
  localparam int LAT_C  = 9;
`endif

  logic          Clk = 1'b0;
  logic          Clear_bar = 1'b0;
  logic          Vid_req = 1'b0;
  logic [AW-1:0] Vid_addr = '0;
  logic [DW-1:0] Vid_data;
  logic          Vid_valid, Vid_overrun;
  logic          Cpu_req = 1'b0;
  logic          Cpu_we = 1'b0;
  logic [AW-1:0] Cpu_addr = '0;
  logic [DW-1:0] Cpu_wdata = '0;
  logic [DW-1:0] Cpu_rdata;
  logic          Cpu_ack, Cpu_wait, Mux_select, Mux_enable_bar;
  logic [AW-1:0] Ram_addr;
  logic [DW-1:0] Ram_wdata;
  logic          Ram_we_bar, Ram_oe_bar;
  logic [DW-1:0] Ram_rdata;

  vram_mux_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Clear_bar(Clear_bar),
    .Vid_req(Vid_req), .Vid_addr(Vid_addr), .Vid_data(Vid_data),
    .Vid_valid(Vid_valid), .Vid_overrun(Vid_overrun),
    .Cpu_req(Cpu_req), .Cpu_we(Cpu_we), .Cpu_addr(Cpu_addr), .Cpu_wdata(Cpu_wdata),
    .Cpu_rdata(Cpu_rdata), .Cpu_ack(Cpu_ack), .Cpu_wait(Cpu_wait),
    .Mux_select(Mux_select), .Mux_enable_bar(Mux_enable_bar),
    .Ram_addr(Ram_addr), .Ram_wdata(Ram_wdata),
    .Ram_we_bar(Ram_we_bar), .Ram_oe_bar(Ram_oe_bar), .Ram_rdata(Ram_rdata)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // asynchronous RAM model
  logic [DW-1:0] mem [0:2047];
  assign Ram_rdata = (!Ram_oe_bar) ? mem[Ram_addr] : '0;
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h123] = 8'hA5;
    mem[11'h045] = 8'h3E;
    mem[11'h100] = 8'h81;
    mem[11'h101] = 8'h82;
    mem[11'h200] = 8'h11;
    forever begin
      @(negedge Clk);
      if (!Ram_we_bar) mem[Ram_addr] = Ram_wdata;
    end
  end

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } vid_exp_t;
  typedef struct { logic [AW-1:0] addr; logic rd; logic [DW-1:0] data; int cyc; } cpu_exp_t;
  vid_exp_t vid_q[$];
  cpu_exp_t cpu_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor
  vid_exp_t      mv;
  cpu_exp_t      mc;
  logic [AW-1:0] prev_addr = '0;
  int            we_run = 0;
  always @(negedge Clk) begin
    if (Clear_bar) begin
      if (Vid_valid) begin
        if (vid_q.size() == 0) chk("vid_unexpected_valid", 1, 0);
        else begin
          mv = vid_q.pop_front();
          chk("vid_valid_cycle", cyc, mv.cyc);
          chk("vid_data", Vid_data, mv.data);
        end
      end
      if (Cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_unexpected_ack", 1, 0);
        else begin
          mc = cpu_q.pop_front();
          chk("cpu_ack_cycle", cyc, mc.cyc);
          if (mc.rd) chk("cpu_rdata", Cpu_rdata, mc.data);
        end
      end
      if (!Ram_oe_bar || !Ram_we_bar) begin
        if (Mux_select == 1'b0) begin
          if (vid_q.size() == 0) chk("vid_strobe_unexpected", 1, 0);
          else chk("vid_ram_addr", Ram_addr, vid_q[0].addr);
        end else begin
          if (cpu_q.size() == 0) chk("cpu_strobe_unexpected", 1, 0);
          else chk("cpu_ram_addr", Ram_addr, cpu_q[0].addr);
        end
      end
      if (!Ram_we_bar) begin
        we_run++;
        chk("we_addr_setup", Ram_addr, prev_addr);
      end else if (we_run != 0) begin
        chk("we_pulse_width", we_run, 1);
        we_run = 0;
      end
    end
    prev_addr = Ram_addr;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic vid_pulse(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int lat, input bit push);
    vid_exp_t e;
    if (push) begin
      e.addr = addr; e.data = data; e.cyc = cyc + lat;
      vid_q.push_back(e);
    end
    Vid_req  = 1'b1;
    Vid_addr = addr;
    tick(1);
    Vid_req  = 1'b0;
  endtask

  task automatic cpu_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] exp_rd, input int lat);
    cpu_exp_t e;
    int n;
    bit got;
    e.addr = addr; e.rd = !we; e.data = exp_rd; e.cyc = cyc + lat;
    cpu_q.push_back(e);
    Cpu_req = 1'b1; Cpu_we = we; Cpu_addr = addr; Cpu_wdata = wd;
    got = 1'b0;
    n = 0;
    while (!got && n < lat + 8) begin
      @(negedge Clk);
      if (Cpu_ack) got = 1'b1;
      else chk("cpu_wait_high", Cpu_wait, 1);
      n++;
    end
    if (!got) chk("cpu_ack_timeout", 0, 1);
    else chk("cpu_wait_low_at_ack", Cpu_wait, 0);
    @(posedge Clk);
    #1;
    Cpu_req = 1'b0;
    Cpu_we  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_vid_data"}, Vid_data, 0);
    chk({tag, "_vid_valid"}, Vid_valid, 0);
    chk({tag, "_vid_overrun"}, Vid_overrun, 0);
    chk({tag, "_cpu_rdata"}, Cpu_rdata, 0);
    chk({tag, "_cpu_ack"}, Cpu_ack, 0);
    chk({tag, "_mux_select"}, Mux_select, 0);
    chk({tag, "_mux_enable_bar"}, Mux_enable_bar, 1);
    chk({tag, "_ram_addr"}, Ram_addr, 0);
    chk({tag, "_ram_wdata"}, Ram_wdata, 0);
    chk({tag, "_ram_we_bar"}, Ram_we_bar, 1);
    chk({tag, "_ram_oe_bar"}, Ram_oe_bar, 1);
  endtask

  logic [AW-1:0] s_addr [3];
  logic [DW-1:0] s_data [3];

  initial begin
    s_addr[0] = 11'h123; s_data[0] = 8'hA5;
    s_addr[1] = 11'h045; s_data[1] = 8'h3E;
    s_addr[2] = 11'h100; s_data[2] = 8'h81;

    tick(2);
    check_reset_values("por");
    chk("por_cpu_wait", Cpu_wait, 0);
    Clear_bar = 1'b1;
    tick(2);

    vid_pulse(11'h123, 8'hA5, 3, 1'b1);
    tick(5);

    cpu_txn(1'b1, 11'h7FF, 8'h3C, 8'h00, 3);
    tick(1);
    cpu_txn(1'b0, 11'h7FF, 8'h00, 8'h3C, 3);
    tick(2);

    // collision: video first, CPU acked six cycles after request
    fork
      vid_pulse(11'h045, 8'h3E, 3, 1'b1);
      cpu_txn(1'b0, 11'h7FF, 8'h00, 8'h3C, 6);
    join
    tick(2);

    // video every third cycle with CPU held: priority depends on build
    fork
      begin
        vid_pulse(11'h100, 8'h81, 3, 1'b1);
        tick(2);
        vid_pulse(11'h101, 8'h82, LAT_V2, 1'b1);
      end
      cpu_txn(1'b0, 11'h045, 8'h00, 8'h3E, LAT_C);
    join
    tick(12);

    // overrun: two requests while the CPU owns the RAM, only the newer is fetched
    chk("overrun_initially_clear", Vid_overrun, 0);
    fork
      cpu_txn(1'b0, 11'h123, 8'h00, 8'hA5, 3);
      begin
        tick(1);
        vid_pulse(11'h045, 8'h00, 0, 1'b0);
        vid_pulse(11'h100, 8'h81, 5, 1'b1);
      end
    join
    tick(6);
    chk("overrun_set", Vid_overrun, 1);

    // reset in the middle of a CPU write, with a video request pending
    Cpu_req = 1'b1; Cpu_we = 1'b1; Cpu_addr = 11'h200; Cpu_wdata = 8'h77;
    tick(1);
    Vid_req = 1'b1; Vid_addr = 11'h101;
    tick(1);
    Vid_req = 1'b0;
    #2;
    chk("we_low_before_reset", Ram_we_bar, 0);
    Clear_bar = 1'b0;
    #1;
    check_reset_values("midreset");
    Cpu_req = 1'b0; Cpu_we = 1'b0;
    tick(2);
    Clear_bar = 1'b1;
    tick(8);
    cpu_txn(1'b0, 11'h200, 8'h00, 8'h11, 3);
    tick(2);

`ifndef VRAM_ARB_FAIR_EN
    // strict priority: CPU starves for 100 cycles of back-to-back fetches
    fork
      for (int k = 0; k < 34; k++) begin
        vid_pulse(s_addr[k % 3], s_data[k % 3], 3, 1'b1);
        tick(2);
      end
      cpu_txn(1'b0, 11'h7FF, 8'h00, 8'h3C, 105);
    join
    tick(2);
`endif

    tick(4);
    chk("vid_queue_drained", vid_q.size(), 0);
    chk("cpu_queue_drained", cpu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vram_mux_arbiter.md
# vram_mux_arbiter

- Sequencing controller for the shared video-RAM address/data path on the board model.
- Time-shares one asynchronous VRAM between the CPU bus and the video fetch unit.
- Drives the select and enable of the VRAM address multiplexer, plus RAM strobes, latched read data and CPU wait/ack.
- Sits between the CPU decode logic, the tile/sprite fetch logic and the VRAM chip model.

## Interface
Parameters:
- ADDR_WIDTH, 11, VRAM address bits
- DATA_WIDTH, 8, VRAM data bits

Ports:
- Clk  in  1  system clock, all state on rising edge
- Clear_bar  in  1  asynchronous active-low reset
- Vid_req  in  1  single-cycle video fetch request
- Vid_addr  in  ADDR_WIDTH  fetch address, sampled with Vid_req
- Vid_data  out  DATA_WIDTH  fetched data, held until next video read
- Vid_valid  out  1  one-cycle pulse, Vid_data updated
- Vid_overrun  out  1  sticky: Vid_req arrived while a fetch was still pending
- Cpu_req  in  1  level request, held until Cpu_ack
- Cpu_we  in  1  1 = write, sampled with Cpu_req acceptance
- Cpu_addr  in  ADDR_WIDTH  CPU address
- Cpu_wdata  in  DATA_WIDTH  CPU write data
- Cpu_rdata  out  DATA_WIDTH  read data, valid during Cpu_ack
- Cpu_ack  out  1  one-cycle completion pulse
- Cpu_wait  out  1  Cpu_req high and Cpu_ack low (combinational)
- Mux_select  out  1  0 = video address, 1 = CPU address
- Mux_enable_bar  out  1  0 = mux outputs enabled
- Ram_addr  out  ADDR_WIDTH  muxed VRAM address
- Ram_wdata  out  DATA_WIDTH  registered CPU write data
- Ram_we_bar, Ram_oe_bar  out  1  active-low RAM strobes
- Ram_rdata  in  DATA_WIDTH  RAM data out

## Operation
- Video pending flag and address register:
  - Set by Vid_req.
  - Cleared on entering VID_SETUP.
  - Vid_req while the flag is set sets Vid_overrun. The newer address replaces the older one.
- States:
  - IDLE: mux disabled, strobes high.
  - VID_SETUP: Mux_select=0, enable low, Ram_oe_bar low.
  - VID_READ: Ram_rdata latched into Vid_data at exit.
  - CPU_SETUP: Mux_select=1, Cpu_we/Cpu_wdata captured.
  - CPU_ACCESS: Ram_we_bar low if write, else Ram_oe_bar low. Ram_rdata latched at exit.
  - CPU_DONE: Cpu_ack high, strobes high, mux disabled.
- Transitions:
  - IDLE → VID_SETUP if video pending. Otherwise IDLE → CPU_SETUP if Cpu_req.
  - VID_SETUP → VID_READ → IDLE.
  - CPU_SETUP → CPU_ACCESS → CPU_DONE → IDLE.
- CPU handshake:
  - Requester drops Cpu_req in the cycle after Cpu_ack.
  - Cpu_req is never sampled in CPU_DONE, so there is no double grant.
- Mux_select changes only on entry to a SETUP state. Address is stable one cycle before and throughout any strobe.

## Timing
- Reset values: all data outputs 0, Vid_valid/Cpu_ack/Vid_overrun 0, Mux_select 0, Mux_enable_bar 1, Ram_we_bar 1, Ram_oe_bar 1, state IDLE, pending flag clear.
- Video latency: Vid_req at edge N (FSM idle) → VID_SETUP at N+1, VID_READ at N+2, Vid_valid at N+3.
- CPU latency: Cpu_req seen in IDLE at edge N → Cpu_ack high at N+3. Cpu_wait high for cycles N..N+2.
- Simultaneous video pending and Cpu_req in IDLE: video wins (default build).
- Reset mid-access: strobes return high asynchronously. An in-flight write is aborted, no ack issued, pending flag cleared.

## Configuration
- VRAM_ARB_FAIR_EN defined:
  - A one-bit "last grant" register alternates priority.
  - If the last grant was video and Cpu_req is high, the CPU wins the next IDLE even with video pending.
  - Worst-case CPU wait is one video access.
- Undefined: strict video priority. The CPU can stall indefinitely under back-to-back Vid_req.

## Structure
- Package vram_arb_pkg: state enum (6 states, 3-bit encoding), MUX_SEL_VID/MUX_SEL_CPU constants.
- Sub-module vram_addr_mux: ADDR_WIDTH-wide 2:1 mux with active-low enable (output 0 when disabled). Driven by Mux_select/Mux_enable_bar, produces Ram_addr.

## Test plan
- Reset: Clear_bar low mid-CPU_ACCESS write → Ram_we_bar=1 immediately, Cpu_ack never pulses, all outputs at reset values.
- Video read: RAM[0x123]=0xA5, Vid_req with 0x123 → Vid_valid at +3 cycles, Vid_data=0xA5, Ram_addr=0x123 during VID_SETUP/VID_READ.
- CPU write then read: write 0x3C to 0x7FF, then read 0x7FF → two Cpu_ack pulses 3 cycles after each request, Cpu_rdata=0x3C. Ram_we_bar low for exactly one cycle.
- Collision (default build): Vid_req and Cpu_req in same cycle → video serviced first, Cpu_ack at +6 cycles, Cpu_wait high throughout.
- Fairness (VRAM_ARB_FAIR_EN): Vid_req every 3 cycles with Cpu_req held → CPU acked within 6 cycles of request. Without the macro, no ack over 100 cycles.
- Overrun: two Vid_req 1 cycle apart while FSM busy on CPU → Vid_overrun=1, only the second address fetched.
